// File: rtl/voxel_sched_pkg.sv
// Shared types and sizing helpers for the voxel layer scheduler.
package voxel_sched_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StBlank,
      StStart,
      StWait,
      StOn,
      StFault
   } sched_state_t;

   // Width that holds the largest of the three cycle counts without wrapping.
   function automatic int unsigned cnt_width(input int unsigned on_cycles,
                                             input int unsigned dead_cycles,
                                             input int unsigned timeout);
      int unsigned max_val;
      max_val = on_cycles;
      if (dead_cycles > max_val) max_val = dead_cycles;
      if (timeout > max_val) max_val = timeout;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sched_down_counter.sv
// Loadable down counter; done_o flags the final counted cycle (value 1), so a load
// of N gives a window of exactly N cycles.
module sched_down_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             spiClk,
   input  logic             nReset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             done_o
);

   logic [WIDTH-1:0] value_d, value_q;

   always_comb begin
      value_d = value_q;
      if (load_i) begin
         value_d = load_val_i;
      end else if (dec_i && (value_q != '0)) begin
         value_d = value_q - WIDTH'(1);
      end
   end

   always_ff @(posedge spiClk) begin
      if (!nReset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign done_o = (value_q == WIDTH'(1));

endmodule

// File: rtl/voxel_layer_scheduler.sv
// Layer multiplexing sequencer: blanks, kicks the LED shift engine, waits for it,
// then lights one layer; owns layer index, display bank and the shift watchdog.
module voxel_layer_scheduler
   import voxel_sched_pkg::*;
#(
   parameter int unsigned NUM_LAYERS  = 8,
   parameter int unsigned ON_CYCLES   = 4096,
   parameter int unsigned DEAD_CYCLES = 16,
   parameter int unsigned TIMEOUT     = 8192
) (
   input  logic                          spiClk,
   input  logic                          nReset,
   input  logic                          enable,
   output logic                          ledStart,
   input  logic                          ledDone,
   input  logic                          ledBusy,
   output logic [$clog2(NUM_LAYERS)-1:0] layerIdx,
   output logic [NUM_LAYERS-1:0]         layerEn,
   output logic                          bankSel,
   input  logic                          swapReq,
   output logic                          swapAck,
   output logic                          frameDone,
   output logic                          running,
   output logic                          fault
);

   localparam int unsigned IW = $clog2(NUM_LAYERS);
   localparam int unsigned CW = cnt_width(ON_CYCLES, DEAD_CYCLES, TIMEOUT);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_LAYERS - 1);
   localparam logic [CW-1:0] ON_LOAD   = CW'(ON_CYCLES);
   localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYCLES);
   localparam logic [CW-1:0] TO_LOAD   = CW'(TIMEOUT);

   sched_state_t  state_d, state_q;
   logic [IW-1:0] idx_d, idx_q;
   logic          bank_d, bank_q;
   logic          pend_d, pend_q;
   logic          swap_req_q;
   logic          swap_rise;

   logic          ph_load, ph_dec, ph_done;
   logic [CW-1:0] ph_val;
   logic          wd_load, wd_dec, wd_done;

   assign swap_rise = swapReq & ~swap_req_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      bank_d    = bank_q;
      pend_d    = pend_q | swap_rise;
      ph_load   = 1'b0;
      ph_val    = DEAD_LOAD;
      wd_load   = 1'b0;
      ledStart  = 1'b0;
      frameDone = 1'b0;
      swapAck   = 1'b0;
      ph_dec    = (state_q == StBlank) || (state_q == StOn);
      wd_dec    = (state_q == StStart) || (state_q == StWait);

      unique case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StBlank;
               ph_load = 1'b1;
            end
         end
         StBlank: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (ph_done) begin
               state_d = StStart;
               wd_load = 1'b1;
            end
         end
         StStart: begin
            // Watchdog expiry wins so a start is never issued into a fault.
            if (wd_done) begin
               state_d = StFault;
            end else if (!ledBusy) begin
               ledStart = 1'b1;
               state_d  = StWait;
            end
         end
         StWait: begin
            if (ledDone) begin
               state_d = StOn;
               ph_load = 1'b1;
               ph_val  = ON_LOAD;
            end else if (wd_done) begin
               state_d = StFault;
            end
         end
         StOn: begin
            if (ph_done) begin
               idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
               if (idx_q == LAST_IDX) begin
                  frameDone = 1'b1;
                  // A request edge arriving on the boundary cycle still counts.
                  if (pend_q || swap_rise) begin
                     bank_d  = ~bank_q;
                     swapAck = 1'b1;
                     pend_d  = 1'b0;
                  end
               end
               if (enable) begin
                  state_d = StBlank;
                  ph_load = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StFault: begin
            state_d = StFault;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge spiClk) begin
      if (!nReset) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         bank_q     <= 1'b0;
         pend_q     <= 1'b0;
         swap_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         bank_q     <= bank_d;
         pend_q     <= pend_d;
         swap_req_q <= swapReq;
      end
   end

   sched_down_counter #(
      .WIDTH(CW)
   ) u_phase_timer (
      .spiClk    (spiClk),
      .nReset    (nReset),
      .load_i    (ph_load),
      .load_val_i(ph_val),
      .dec_i     (ph_dec),
      .done_o    (ph_done)
   );

   sched_down_counter #(
      .WIDTH(CW)
   ) u_watchdog (
      .spiClk    (spiClk),
      .nReset    (nReset),
      .load_i    (wd_load),
      .load_val_i(TO_LOAD),
      .dec_i     (wd_dec),
      .done_o    (wd_done)
   );

   assign layerEn  = (state_q == StOn) ? (NUM_LAYERS'(1) << idx_q) : '0;
   assign layerIdx = idx_q;
   assign bankSel  = bank_q;
   assign running  = (state_q != StIdle) && (state_q != StFault);
   assign fault    = (state_q == StFault);

endmodule

// File: tb/tb_voxel_layer_scheduler.sv
// Directed bench: 4 layers, ON=20, DEAD=3, TIMEOUT=50, engine answers 10 cycles after start.
module tb_voxel_layer_scheduler;

   localparam int HIST = 512;

   logic       spiClk = 1'b0;
   logic       nReset = 1'b0;
   logic       enable = 1'b0;
   logic       ledBusy = 1'b0;
   logic       swapReq = 1'b0;
   logic       ledDone;
   logic       ledStart;
   logic [1:0] layerIdx;
   logic [3:0] layerEn;
   logic       bankSel, swapAck, frameDone, running, fault;

   int cyc = 0;
   int base = 0;
   int n_cmp = 0;
   int n_err = 0;
   bit resp_en = 1'b1;
   int man_req = 0;
   int man_seen = 0;
   int eng_t = 0;
   int rel, cur_val, cur_len, dark_cnt;

   int start_q[$], frame_q[$], ack_q[$], dark_q[$], run_val_q[$], run_len_q[$];
   int en_hist[HIST], idx_hist[HIST], bank_hist[HIST], run_hist[HIST], fault_hist[HIST];

   voxel_layer_scheduler #(
      .NUM_LAYERS (4),
      .ON_CYCLES  (20),
      .DEAD_CYCLES(3),
      .TIMEOUT    (50)
   ) dut (
      .spiClk   (spiClk),
      .nReset   (nReset),
      .enable   (enable),
      .ledStart (ledStart),
      .ledDone  (ledDone),
      .ledBusy  (ledBusy),
      .layerIdx (layerIdx),
      .layerEn  (layerEn),
      .bankSel  (bankSel),
      .swapReq  (swapReq),
      .swapAck  (swapAck),
      .frameDone(frameDone),
      .running  (running),
      .fault    (fault)
   );

   initial forever #5 spiClk = ~spiClk;
   initial forever begin
      @(posedge spiClk);
      cyc++;
   end

   // Shift-engine model: cmdDone 10 cycles after a sampled cmdStart, plus manual pulses.
   initial begin
      ledDone = 1'b0;
      forever begin
         @(negedge spiClk);
         ledDone = 1'b0;
         if (!nReset) begin
            eng_t = 0;
         end else begin
            if (eng_t > 0) begin
               eng_t--;
               if (eng_t == 0) ledDone = 1'b1;
            end
            if (ledStart && resp_en) eng_t = 10;
         end
         if (man_req != man_seen) begin
            ledDone  = 1'b1;
            man_seen = man_req;
         end
      end
   end

   // Event recorder, cycle numbers relative to reset release.
   initial begin
      cur_val = 0;
      cur_len = 0;
      dark_cnt = 0;
      forever begin
         @(negedge spiClk);
         rel = cyc - base;
         if (rel >= 0 && rel < HIST) begin
            en_hist[rel]    = int'(layerEn);
            idx_hist[rel]   = int'(layerIdx);
            bank_hist[rel]  = int'(bankSel);
            run_hist[rel]   = int'(running);
            fault_hist[rel] = int'(fault);
         end
         if (!nReset) begin
            start_q.delete(); frame_q.delete(); ack_q.delete(); dark_q.delete();
            run_val_q.delete(); run_len_q.delete();
            cur_len = 0;
            dark_cnt = 0;
         end else begin
            if (ledStart) begin
               start_q.push_back(rel);
               dark_q.push_back(dark_cnt);
            end
            if (frameDone) frame_q.push_back(rel);
            if (swapAck) ack_q.push_back(rel);
            if (layerEn != 4'b0) begin
               if (cur_len > 0 && int'(layerEn) != cur_val) begin
                  run_val_q.push_back(cur_val);
                  run_len_q.push_back(cur_len);
                  cur_len = 0;
               end
               cur_val = int'(layerEn);
               cur_len++;
            end else if (cur_len > 0) begin
               run_val_q.push_back(cur_val);
               run_len_q.push_back(cur_len);
               cur_len = 0;
            end
            dark_cnt = (running && layerEn == 4'b0) ? dark_cnt + 1 : 0;
         end
      end
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic wait_rel(input int n);
      while (cyc - base < n) begin
         @(posedge spiClk);
         #1;
      end
   endtask

   task automatic do_reset(input bit en_after, input string tag);
      nReset  = 1'b0;
      enable  = 1'b0;
      swapReq = 1'b0;
      ledBusy = 1'b0;
      @(posedge spiClk);
      #1;
      check_eq({tag, " rst layerEn"}, int'(layerEn), 0);
      check_eq({tag, " rst layerIdx"}, int'(layerIdx), 0);
      check_eq({tag, " rst bankSel"}, int'(bankSel), 0);
      check_eq({tag, " rst running"}, int'(running), 0);
      check_eq({tag, " rst fault"}, int'(fault), 0);
      check_eq({tag, " rst ledStart"}, int'(ledStart), 0);
      check_eq({tag, " rst swapAck"}, int'(swapAck), 0);
      check_eq({tag, " rst frameDone"}, int'(frameDone), 0);
      @(posedge spiClk);
      #1;
      base   = cyc;
      nReset = 1'b1;
      enable = en_after;
   endtask

   initial begin
      // 1: free-running frame
      resp_en = 1'b1;
      do_reset(1'b1, "t1");
      wait_rel(145);
      check_eq("t1 start0", qat(start_q, 0), 4);
      check_eq("t1 start1", qat(start_q, 1), 38);
      check_eq("t1 start2", qat(start_q, 2), 72);
      check_eq("t1 start3", qat(start_q, 3), 106);
      check_eq("t1 start4", qat(start_q, 4), 140);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("t1 run%0d val", i), qat(run_val_q, i), 1 << i);
         check_eq($sformatf("t1 run%0d len", i), qat(run_len_q, i), 20);
         check_eq($sformatf("t1 dark%0d", i), qat(dark_q, i), 3);
      end
      check_eq("t1 frame cnt", frame_q.size(), 1);
      check_eq("t1 frame at", qat(frame_q, 0), 136);
      check_eq("t1 dark gap", en_hist[35], 0);
      check_eq("t1 idx wrap", idx_hist[137], 0);

      // 2: bank swap at frame boundary, held request does not re-arm
      do_reset(1'b1, "t2");
      wait_rel(50);
      swapReq = 1'b1;
      wait_rel(285);
      check_eq("t2 ack cnt", ack_q.size(), 1);
      check_eq("t2 ack at", qat(ack_q, 0), 136);
      check_eq("t2 bank pre", bank_hist[136], 0);
      check_eq("t2 bank post", bank_hist[137], 1);
      check_eq("t2 frame cnt", frame_q.size(), 2);
      check_eq("t2 frame2 at", qat(frame_q, 1), 272);
      check_eq("t2 bank end", int'(bankSel), 1);

      // 3: enable dropped in WAIT of layer 1
      do_reset(1'b1, "t3");
      wait_rel(42);
      enable = 1'b0;
      wait_rel(80);
      check_eq("t3 running wait", run_hist[48], 1);
      check_eq("t3 on val", qat(run_val_q, 1), 2);
      check_eq("t3 on len", qat(run_len_q, 1), 20);
      check_eq("t3 idle en", en_hist[69], 0);
      check_eq("t3 idle run", run_hist[69], 0);
      check_eq("t3 idle idx", idx_hist[69], 2);
      check_eq("t3 still idle", run_hist[79], 0);
      enable = 1'b1;
      wait_rel(120);
      check_eq("t3 resume start", qat(start_q, 2), 84);
      check_eq("t3 resume idx", idx_hist[84], 2);
      check_eq("t3 resume en", en_hist[95], 4);

      // 4: shift engine never answers
      resp_en = 1'b0;
      do_reset(1'b1, "t4");
      wait_rel(60);
      check_eq("t4 fault pre", fault_hist[53], 0);
      check_eq("t4 fault at", fault_hist[54], 1);
      check_eq("t4 fault en", en_hist[54], 0);
      check_eq("t4 fault run", run_hist[54], 0);
      man_req++;
      wait_rel(70);
      enable = 1'b0;
      wait_rel(75);
      enable = 1'b1;
      wait_rel(90);
      check_eq("t4 sticky fault", int'(fault), 1);
      check_eq("t4 sticky en", int'(layerEn), 0);
      check_eq("t4 sticky run", int'(running), 0);
      check_eq("t4 starts", start_q.size(), 1);

      // 5: engine busy for 7 cycles at START entry
      do_reset(1'b1, "t5");
      wait_rel(3);
      ledBusy = 1'b1;
      wait_rel(11);
      ledBusy = 1'b0;
      wait_rel(60);
      check_eq("t5 starts", start_q.size(), 1);
      check_eq("t5 start at", qat(start_q, 0), 11);
      check_eq("t5 fault pre", fault_hist[53], 0);
      check_eq("t5 fault at", fault_hist[54], 1);

      // 6: reset in ON of layer 2 with bank 1
      resp_en = 1'b1;
      do_reset(1'b1, "t6");
      wait_rel(10);
      swapReq = 1'b1;
      wait_rel(224);
      check_eq("t6 pre en", int'(layerEn), 4);
      check_eq("t6 pre bank", int'(bankSel), 1);
      wait_rel(225);
      do_reset(1'b1, "t6b");
      wait_rel(12);
      check_eq("t6 first start", qat(start_q, 0), 4);
      check_eq("t6 first dark", qat(dark_q, 0), 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/voxel_layer_scheduler.md
Name: voxel_layer_scheduler

Overview:
Sequences the LED shift engine one voxel layer at a time and drives the layer-select transistors so that only one layer is lit, never while new data is shifting.
- Owns the layer index, which supplies the upper read-address bits for the column buffer.
- Owns the double-buffer bank select, which it swaps only at frame boundaries.
- Runs a done-watchdog on the shift engine.
- Sits between the host frame-buffer writer and the LED shift engine (cmdStart/cmdDone/busy handshake).

Parameters:
NUM_LAYERS, 8, number of voxel layers multiplexed per frame (at least 2).
ON_CYCLES, 4096, spiClk cycles a layer stays lit (at least 1).
DEAD_CYCLES, 16, spiClk cycles with all layers off before each shift/latch (at least 1).
TIMEOUT, 8192, maximum spiClk cycles from ledStart to ledDone before fault.

Ports:
spiClk  input  1  clock
nReset  input  1  synchronous active-low reset
enable  input  1  level; 1 = run the scan, 0 = stop at next safe point
ledStart  output  1  one-cycle pulse to the shift engine's cmdStart
ledDone  input  1  one-cycle pulse from the shift engine's cmdDone
ledBusy  input  1  shift engine busy
layerIdx  output  $clog2(NUM_LAYERS)  current layer; read-address upper bits
layerEn  output  NUM_LAYERS  one-hot layer drive; all zero when dark
bankSel  output  1  frame buffer bank currently displayed
swapReq  input  1  host requests bank swap (rising edge significant)
swapAck  output  1  one-cycle pulse when the swap is performed
frameDone  output  1  one-cycle pulse after the last layer's ON period
running  output  1  1 in any state other than IDLE/FAULT
fault  output  1  sticky; ledDone timeout occurred

Behaviour:
- Reset (nReset=0 at a posedge spiClk) forces state IDLE and drives every output to 0.
  - This includes layerEn, layerIdx, bankSel, swapPending, fault and all counters.
  - Reset applies mid-operation as well; no handshake with the shift engine is attempted.
- States: IDLE, BLANK, START, WAIT, ON, FAULT.
- IDLE: layerEn=0. If enable=1, the next state is BLANK with layerIdx kept and the counter loaded with DEAD_CYCLES.
- BLANK: layerEn=0 for exactly DEAD_CYCLES cycles, then START.
- START: asserts ledStart for one cycle, in the first cycle where ledBusy=0, then moves to WAIT.
  - While ledBusy=1 it holds in START with ledStart=0.
  - The timeout counter starts on START entry.
- WAIT: waits for ledDone.
  - layerIdx is held constant from BLANK entry through ledDone.
  - When ledDone is sampled 1, the next cycle is ON.
- ON: layerEn = 1<<layerIdx for exactly ON_CYCLES cycles.
  - On the last cycle, layerIdx advances by 1, wrapping at NUM_LAYERS-1 to 0, and the state moves to BLANK.
  - If enable=0, the state moves to IDLE instead.
  - Ending ON always passes through layerEn=0; two layer bits are never set in the same cycle.
- Frame boundary (last ON cycle with layerIdx=NUM_LAYERS-1):
  - frameDone pulses in the same cycle.
  - If swapPending=1, then in that cycle bankSel toggles, swapAck pulses and swapPending clears.
- swapPending is set on a swapReq rising edge (registered compare).
  - A rising edge in the same cycle as the boundary is honoured at that boundary.
  - A held-high swapReq does not re-arm.
- enable=0 is honoured only in IDLE, BLANK or at the end of ON.
  - In START, WAIT or ON the scheduler completes the current layer first, because a shift in progress cannot be aborted.
  - In BLANK it goes to IDLE next cycle.
- Timeout: if WAIT or START lasts TIMEOUT cycles with no ledDone, the state moves to FAULT.
  - In FAULT: fault=1 (sticky), layerEn=0, ledStart=0, running=0.
  - FAULT is left only by reset. A late ledDone arriving in FAULT is ignored.
- ledDone outside WAIT is ignored.
- Counters are sized $clog2 of max(ON_CYCLES, DEAD_CYCLES, TIMEOUT)+1. They are loaded and decremented to 1, with no off-by-one: durations are exact as stated.

Decomposition:
- Package voxel_sched_pkg holds:
  - state enum sched_state_t (IDLE, BLANK, START, WAIT, ON, FAULT)
  - the localparam helper for counter width
- Sub-module sched_down_counter (load, value, decrement, zero flag) is instanced twice: phase timer and watchdog.

Test Plan:
1. NUM_LAYERS=4, ON=20, DEAD=3; enable=1, model ledDone 10 cycles after ledStart.
   - ledStart fires 4 times per frame.
   - layerEn steps 0001, 0010, 0100, 1000, each high exactly 20 cycles, with exactly 3 dark cycles before each ledStart.
   - frameDone pulses once per frame.
2. Same parameters; pulse swapReq mid-frame 1.
   - bankSel toggles 0→1 and swapAck pulses exactly at the end of layer 3 ON.
   - Holding swapReq high afterwards causes no further toggles.
3. Drop enable during WAIT of layer 1.
   - ledDone is still awaited, layer 1 lights for 20 cycles, then IDLE with layerIdx=2 and running=0.
   - Re-enable resumes at layer 2.
4. TIMEOUT=50; never return ledDone.
   - Exactly 50 cycles after START entry: fault=1, layerEn=0.
   - A later ledDone and enable toggles have no effect until nReset=0.
5. Hold ledBusy=1 for 7 cycles on START entry.
   - ledStart is asserted on the 8th cycle only.
   - The timeout count includes those cycles.
6. Assert nReset=0 during ON of layer 2 with bankSel=1.
   - Next cycle all outputs are 0, including bankSel and layerEn.
   - The first ledStart after release follows exactly DEAD cycles of BLANK.
